// File: rtl/latency_memory.sv
// ============================================================================
// Module   : latency_memory
// Purpose  : Dual-port word-addressed memory responding to a CPU instruction
//            port (read-only) and data port (read/write). Each port runs an
//            independent latency FSM and signals completion with a one-cycle
//            ready pulse, driving its shared data bus only for read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module latency_memory #(
  parameter int WORD_SIZE = 16,
  parameter int MEM_DEPTH = 256,
  parameter int I_LATENCY = 2,
  parameter int D_LATENCY = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 i_readM,
  input  logic                 i_writeM,
  input  logic [WORD_SIZE-1:0] i_address,
  inout  wire  [WORD_SIZE-1:0] i_data,
  output logic                 i_ready,
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  inout  wire  [WORD_SIZE-1:0] d_data,
  output logic                 d_ready
);

  localparam int         ADDR_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] I_LOAD = 4'(I_LATENCY - 1);
  localparam logic [3:0] D_LOAD = 4'(D_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

  state_t               i_state_q, i_state_d;
  logic [3:0]           i_cnt_q, i_cnt_d;
  logic [ADDR_W-1:0]    i_addr_q, i_addr_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic                 i_to_ready;

  state_t               d_state_q, d_state_d;
  logic [3:0]           d_cnt_q, d_cnt_d;
  logic [ADDR_W-1:0]    d_addr_q, d_addr_d;
  logic                 d_write_q, d_write_d;
  logic [WORD_SIZE-1:0] d_wdata_q, d_wdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 d_to_ready;
  logic                 d_commit;

  // The i-port is read-only and only the low address bits select a word.
  wire unused_bits = ^{i_writeM, i_address[WORD_SIZE-1:ADDR_W], d_address[WORD_SIZE-1:ADDR_W]};

  // i-port next state: accept in IDLE, count down in BUSY, one READY cycle.
  // The counter is loaded with LATENCY-1 and READY is entered on the edge
  // where it steps from 1 to 0, so ready lands LATENCY cycles after request.
  always_comb begin
    i_state_d  = i_state_q;
    i_cnt_d    = i_cnt_q;
    i_addr_d   = i_addr_q;
    i_rdata_d  = i_rdata_q;
    i_to_ready = 1'b0;
    case (i_state_q)
      ST_IDLE: begin
        if (i_readM) begin
          i_addr_d = i_address[ADDR_W-1:0];
          i_cnt_d  = I_LOAD;
          if (I_LATENCY == 1) begin
            i_state_d  = ST_READY;
            i_to_ready = 1'b1;
          end else begin
            i_state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        i_cnt_d = i_cnt_q - 4'd1;
        if (i_cnt_q <= 4'd1) begin
          i_state_d  = ST_READY;
          i_to_ready = 1'b1;
        end
      end
      ST_READY: i_state_d = ST_IDLE;
      default:  i_state_d = ST_IDLE;
    endcase
    // Array is sampled before any same-edge d-write lands: read-before-write.
    if (i_to_ready) i_rdata_d = mem_q[i_addr_d];
  end

  // i-port state registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      i_state_q <= ST_IDLE;
      i_cnt_q   <= 4'd0;
      i_addr_q  <= '0;
      i_rdata_q <= '0;
    end else begin
      i_state_q <= i_state_d;
      i_cnt_q   <= i_cnt_d;
      i_addr_q  <= i_addr_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  // d-port next state; a simultaneous read+write request is taken as a write.
  always_comb begin
    d_state_d  = d_state_q;
    d_cnt_d    = d_cnt_q;
    d_addr_d   = d_addr_q;
    d_write_d  = d_write_q;
    d_wdata_d  = d_wdata_q;
    d_rdata_d  = d_rdata_q;
    d_to_ready = 1'b0;
    case (d_state_q)
      ST_IDLE: begin
        if (d_readM || d_writeM) begin
          d_addr_d  = d_address[ADDR_W-1:0];
          d_write_d = d_writeM;
          if (d_writeM) d_wdata_d = d_data;
          d_cnt_d   = D_LOAD;
          if (D_LATENCY == 1) begin
            d_state_d  = ST_READY;
            d_to_ready = 1'b1;
          end else begin
            d_state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        d_cnt_d = d_cnt_q - 4'd1;
        if (d_cnt_q <= 4'd1) begin
          d_state_d  = ST_READY;
          d_to_ready = 1'b1;
        end
      end
      ST_READY: d_state_d = ST_IDLE;
      default:  d_state_d = ST_IDLE;
    endcase
    if (d_to_ready && !d_write_d) d_rdata_d = mem_q[d_addr_d];
  end

  // d-port state registers; reset drops any uncommitted write.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      d_state_q <= ST_IDLE;
      d_cnt_q   <= 4'd0;
      d_addr_q  <= '0;
      d_write_q <= 1'b0;
      d_wdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      d_state_q <= d_state_d;
      d_cnt_q   <= d_cnt_d;
      d_addr_q  <= d_addr_d;
      d_write_q <= d_write_d;
      d_wdata_q <= d_wdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign d_commit = d_to_ready && d_write_d && !Reset;

  // Write commit on the edge that enters READY; contents survive reset.
  always_ff @(posedge Clk) begin
    if (d_commit) mem_q[d_addr_d] <= d_wdata_d;
  end

  assign i_ready = (i_state_q == ST_READY);
  assign d_ready = (d_state_q == ST_READY);
  assign i_data  = (i_state_q == ST_READY) ? i_rdata_q : {WORD_SIZE{1'bz}};
  assign d_data  = (d_state_q == ST_READY && !d_write_q) ? d_rdata_q : {WORD_SIZE{1'bz}};

endmodule

`default_nettype wire
